// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file scoreboard.
package regfile_pkg;

    localparam int unsigned ADDR_WIDTH      = 5;
    localparam int unsigned BUS_WIDTH       = 32;
    localparam int unsigned NUM_REGS        = 2 ** ADDR_WIDTH;
    localparam int unsigned MAX_OUTSTANDING = 4;
    localparam int unsigned STALL_CNT_WIDTH = 32;

    typedef logic [ADDR_WIDTH-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Issue, writeback and status bundle between decode/issue and the scoreboard.
interface regfile_scoreboard_if #(
    parameter int unsigned ADDR_WIDTH      = regfile_pkg::ADDR_WIDTH,
    parameter int unsigned MAX_OUTSTANDING = regfile_pkg::MAX_OUTSTANDING,
    parameter int unsigned STALL_CNT_WIDTH = regfile_pkg::STALL_CNT_WIDTH
);
    localparam int unsigned NUM_REGS  = 2 ** ADDR_WIDTH;
    localparam int unsigned OUT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

    logic                       iss_valid;
    logic                       iss_ready;
    logic [ADDR_WIDTH-1:0]      iss_rs1_addr;
    logic                       iss_rs1_used;
    logic [ADDR_WIDTH-1:0]      iss_rs2_addr;
    logic                       iss_rs2_used;
    logic [ADDR_WIDTH-1:0]      iss_rd_addr;
    logic                       iss_rd_we;
    logic                       wb_valid;
    logic [ADDR_WIDTH-1:0]      wb_rd_addr;
    logic                       flush;
    logic [NUM_REGS-1:0]        busy_vec;
    logic [OUT_WIDTH-1:0]       outstanding;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt;
    logic                       wb_err;

    modport master (
        output iss_valid, iss_rs1_addr, iss_rs1_used, iss_rs2_addr, iss_rs2_used,
               iss_rd_addr, iss_rd_we, wb_valid, wb_rd_addr, flush,
        input  iss_ready, busy_vec, outstanding, stall_cnt, wb_err
    );

    modport slave (
        input  iss_valid, iss_rs1_addr, iss_rs1_used, iss_rs2_addr, iss_rs2_used,
               iss_rd_addr, iss_rd_we, wb_valid, wb_rd_addr, flush,
        output iss_ready, busy_vec, outstanding, stall_cnt, wb_err
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Per-register busy tracking with RAW/WAW issue stall, writeback clear,
// outstanding-write cap and a saturating stall counter.
module regfile_scoreboard #(
    parameter int unsigned ADDR_WIDTH      = regfile_pkg::ADDR_WIDTH,
    parameter int unsigned MAX_OUTSTANDING = regfile_pkg::MAX_OUTSTANDING,
    parameter int unsigned STALL_CNT_WIDTH = regfile_pkg::STALL_CNT_WIDTH
) (
    input logic                  clk,
    input logic                  rst,
    regfile_scoreboard_if.slave  bus
);

    localparam int unsigned NUM_REGS  = 2 ** ADDR_WIDTH;
    localparam int unsigned OUT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > NUM_REGS - 1) begin : g_bad_cap
        $error("MAX_OUTSTANDING out of range");
    end

    logic [NUM_REGS-1:0]  busy_q;
    logic [NUM_REGS-1:0]  busy_d;
    logic [OUT_WIDTH-1:0] outstanding_q;
    logic [OUT_WIDTH-1:0] outstanding_d;
    logic                 wb_err_q;
    logic                 wb_err_d;

    logic track;
    logic src_haz;
    logic dst_haz;
    logic full;
    logic iss_ready_c;
    logic set_en;
    logic wb_live;
    logic clr_en;
    logic stall_inc;

    // Hazard check sees only registered busy state: no writeback bypass.
    always_comb begin
        track   = bus.iss_rd_we & (bus.iss_rd_addr != '0);
        full    = (outstanding_q == OUT_WIDTH'(MAX_OUTSTANDING));
        src_haz = (bus.iss_rs1_used & (bus.iss_rs1_addr != '0) & busy_q[bus.iss_rs1_addr])
                | (bus.iss_rs2_used & (bus.iss_rs2_addr != '0) & busy_q[bus.iss_rs2_addr]);
        dst_haz = track & (busy_q[bus.iss_rd_addr] | full);

        iss_ready_c = ~rst & ~bus.flush & ~src_haz & ~dst_haz;
        stall_inc   = bus.iss_valid & ~iss_ready_c & ~rst;
        set_en      = bus.iss_valid & iss_ready_c & track;

        wb_live = bus.wb_valid & ~bus.flush & (bus.wb_rd_addr != '0);
        clr_en  = wb_live & busy_q[bus.wb_rd_addr];
    end

    // Next busy/outstanding/error state; set and clear never hit the same register.
    always_comb begin
        busy_d        = busy_q;
        outstanding_d = outstanding_q;
        wb_err_d      = wb_err_q | (wb_live & ~busy_q[bus.wb_rd_addr]);

        if (clr_en) begin
            busy_d[bus.wb_rd_addr] = 1'b0;
        end
        if (set_en) begin
            busy_d[bus.iss_rd_addr] = 1'b1;
        end

        case ({set_en, clr_en})
            2'b10:   outstanding_d = outstanding_q + OUT_WIDTH'(1);
            2'b01:   outstanding_d = outstanding_q - OUT_WIDTH'(1);
            default: outstanding_d = outstanding_q;
        endcase

        if (bus.flush) begin
            busy_d        = '0;
            outstanding_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q        <= '0;
            outstanding_q <= '0;
            wb_err_q      <= 1'b0;
        end else begin
            busy_q        <= busy_d;
            outstanding_q <= outstanding_d;
            wb_err_q      <= wb_err_d;
        end
    end

    sat_counter #(
        .WIDTH (STALL_CNT_WIDTH)
    ) u_stall_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (stall_inc),
        .count (bus.stall_cnt)
    );

    assign bus.iss_ready   = iss_ready_c;
    assign bus.busy_vec    = busy_q;
    assign bus.outstanding = outstanding_q;
    assign bus.wb_err      = wb_err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed vector table, random traffic against
// an array-based model, and counter saturation on a narrow-counter instance.
module tb_regfile_scoreboard;
    import regfile_pkg::*;

    typedef struct {
        logic        rst;
        logic        valid;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic [4:0]  rd;
        logic        we;
        logic        wbv;
        logic [4:0]  wbrd;
        logic        flush;
        logic        e_ready;
        logic [31:0] e_busy;
        int          e_out;
        logic        e_err;
        int          e_stall;
    } vec_t;

    logic clk;
    logic rst;
    logic srst;

    regfile_scoreboard_if ifc ();
    regfile_scoreboard_if #(.STALL_CNT_WIDTH(4)) sifc ();

    regfile_scoreboard u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    regfile_scoreboard #(.STALL_CNT_WIDTH(4)) u_small (
        .clk (clk),
        .rst (srst),
        .bus (sifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    bit              m_busy [32];
    bit              m_err;
    longint unsigned m_stall;
    vec_t            tab [25];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic v, input int a1, input logic u1,
                                input int a2, input logic u2, input int d, input logic we,
                                input logic wbv, input int wbrd, input logic fl,
                                input logic er, input logic [31:0] eb, input int eo,
                                input logic ee, input int es);
        vec_t t;
        t.rst = r; t.valid = v; t.rs1 = 5'(a1); t.u1 = u1; t.rs2 = 5'(a2); t.u2 = u2;
        t.rd = 5'(d); t.we = we; t.wbv = wbv; t.wbrd = 5'(wbrd); t.flush = fl;
        t.e_ready = er; t.e_busy = eb; t.e_out = eo; t.e_err = ee; t.e_stall = es;
        return t;
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        for (int i = 0; i < 32; i++) m[i] = m_busy[i];
        return m;
    endfunction

    // Issue is allowed unless reset, flush, a pending source, a pending dest or a full tracker.
    function automatic bit model_ready();
        bit haz = 1'b0;
        if (ifc.iss_rs1_used && ifc.iss_rs1_addr != 0 && m_busy[ifc.iss_rs1_addr]) haz = 1'b1;
        if (ifc.iss_rs2_used && ifc.iss_rs2_addr != 0 && m_busy[ifc.iss_rs2_addr]) haz = 1'b1;
        if (ifc.iss_rd_we && ifc.iss_rd_addr != 0 &&
            (m_busy[ifc.iss_rd_addr] || model_count() == 4)) haz = 1'b1;
        return !rst && !ifc.flush && !haz;
    endfunction

    task automatic model_edge(input bit rdy);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            m_err   = 1'b0;
            m_stall = 0;
            return;
        end
        if (ifc.iss_valid && !rdy && m_stall < 64'hFFFF_FFFF) m_stall++;
        if (ifc.flush) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else begin
            if (ifc.wb_valid && ifc.wb_rd_addr != 0) begin
                if (m_busy[ifc.wb_rd_addr]) m_busy[ifc.wb_rd_addr] = 1'b0;
                else m_err = 1'b1;
            end
            if (ifc.iss_valid && rdy && ifc.iss_rd_we && ifc.iss_rd_addr != 0)
                m_busy[ifc.iss_rd_addr] = 1'b1;
        end
    endtask

    task automatic run_cycle(input bit use_tab, input vec_t t);
        bit rdy;
        #1;
        rdy = model_ready();
        chk("iss_ready", 64'(ifc.iss_ready), 64'(rdy));
        if (use_tab) chk("tab_iss_ready", 64'(ifc.iss_ready), 64'(t.e_ready));
        @(posedge clk);
        model_edge(rdy);
        #1;
        chk("busy_vec", 64'(ifc.busy_vec), 64'(model_mask()));
        chk("outstanding", 64'(ifc.outstanding), 64'(model_count()));
        chk("wb_err", 64'(ifc.wb_err), 64'(m_err));
        chk("stall_cnt", 64'(ifc.stall_cnt), m_stall);
        if (use_tab) begin
            chk("tab_busy_vec", 64'(ifc.busy_vec), 64'(t.e_busy));
            chk("tab_outstanding", 64'(ifc.outstanding), 64'(t.e_out));
            chk("tab_wb_err", 64'(ifc.wb_err), 64'(t.e_err));
            chk("tab_stall_cnt", 64'(ifc.stall_cnt), 64'(t.e_stall));
        end
        @(negedge clk);
    endtask

    task automatic drive(input vec_t t);
        rst              = t.rst;
        ifc.iss_valid    = t.valid;
        ifc.iss_rs1_addr = t.rs1;
        ifc.iss_rs1_used = t.u1;
        ifc.iss_rs2_addr = t.rs2;
        ifc.iss_rs2_used = t.u2;
        ifc.iss_rd_addr  = t.rd;
        ifc.iss_rd_we    = t.we;
        ifc.wb_valid     = t.wbv;
        ifc.wb_rd_addr   = t.wbrd;
        ifc.flush        = t.flush;
    endtask

    initial begin
        vec_t      idle;
        reg_addr_t pick;
        int        q [$];

        idle = mk(1,0, 0,0, 0,0, 0,0, 0,0, 0, 0, 0,0,0,0);
        drive(idle);
        srst = 1'b1;
        sifc.iss_valid = 1'b0; sifc.iss_rs1_addr = '0; sifc.iss_rs1_used = 1'b0;
        sifc.iss_rs2_addr = '0; sifc.iss_rs2_used = 1'b0; sifc.iss_rd_addr = '0;
        sifc.iss_rd_we = 1'b0; sifc.wb_valid = 1'b0; sifc.wb_rd_addr = '0; sifc.flush = 1'b0;
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_err = 1'b0;
        m_stall = 0;

        //            rst v  rs1 u1 rs2 u2 rd we wbv wbrd fl  rdy busy         out err stall
        tab[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0, 32'h0000_0000, 0, 0, 0);
        tab[1]  = mk(0, 1, 0, 0, 0, 0, 5, 1, 0, 0,  0,  1, 32'h0000_0020, 1, 0, 0);
        tab[2]  = mk(0, 1, 5, 1, 0, 0, 0, 0, 0, 0,  0,  0, 32'h0000_0020, 1, 0, 1);
        tab[3]  = mk(0, 1, 0, 1, 5, 1, 0, 0, 0, 0,  0,  0, 32'h0000_0020, 1, 0, 2);
        tab[4]  = mk(0, 1, 5, 1, 0, 0, 0, 0, 1, 5,  0,  0, 32'h0000_0000, 0, 0, 3);
        tab[5]  = mk(0, 1, 5, 1, 0, 0, 0, 0, 0, 0,  0,  1, 32'h0000_0000, 0, 0, 3);
        tab[6]  = mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0,  0,  1, 32'h0000_0000, 0, 0, 3);
        tab[7]  = mk(0, 1, 0, 1, 0, 0, 0, 1, 0, 0,  0,  1, 32'h0000_0000, 0, 0, 3);
        tab[8]  = mk(0, 1, 0, 0, 0, 0, 1, 1, 0, 0,  0,  1, 32'h0000_0002, 1, 0, 3);
        tab[9]  = mk(0, 1, 0, 0, 0, 0, 2, 1, 0, 0,  0,  1, 32'h0000_0006, 2, 0, 3);
        tab[10] = mk(0, 1, 0, 0, 0, 0, 3, 1, 0, 0,  0,  1, 32'h0000_000E, 3, 0, 3);
        tab[11] = mk(0, 1, 0, 0, 0, 0, 4, 1, 0, 0,  0,  1, 32'h0000_001E, 4, 0, 3);
        tab[12] = mk(0, 1, 0, 0, 0, 0, 6, 1, 0, 0,  0,  0, 32'h0000_001E, 4, 0, 4);
        tab[13] = mk(0, 1, 0, 0, 0, 0, 7, 1, 1, 2,  0,  0, 32'h0000_001A, 3, 0, 5);
        tab[14] = mk(0, 1, 0, 0, 0, 0, 7, 1, 0, 0,  0,  1, 32'h0000_009A, 4, 0, 5);
        tab[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1,  0,  1, 32'h0000_0098, 3, 0, 5);
        tab[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 4,  0,  1, 32'h0000_0088, 2, 0, 5);
        tab[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7,  0,  1, 32'h0000_0008, 1, 0, 5);
        tab[18] = mk(0, 1, 0, 0, 0, 0, 9, 1, 0, 0,  0,  1, 32'h0000_0208, 2, 0, 5);
        tab[19] = mk(0, 1, 0, 0, 0, 0,10, 1, 1, 3,  1,  0, 32'h0000_0000, 0, 0, 6);
        tab[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1,12,  0,  1, 32'h0000_0000, 0, 1, 6);
        tab[21] = mk(0, 1, 0, 0, 0, 0,12, 1, 0, 0,  0,  1, 32'h0000_1000, 1, 1, 6);
        tab[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1,12,  0,  1, 32'h0000_0000, 0, 1, 6);
        tab[23] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  0, 32'h0000_0000, 0, 0, 0);
        tab[24] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0,  1, 32'h0000_0000, 0, 0, 0);

        @(negedge clk);
        for (int i = 0; i < 25; i++) begin
            drive(tab[i]);
            run_cycle(1'b1, tab[i]);
        end

        // Random traffic on a narrow address range to provoke frequent hazards.
        for (int c = 0; c < 400; c++) begin
            rst              = ($urandom_range(63) == 0);
            ifc.flush        = ($urandom_range(31) == 0);
            ifc.iss_valid    = ($urandom_range(3) != 0);
            ifc.iss_rs1_addr = 5'($urandom_range(7));
            ifc.iss_rs1_used = 1'($urandom_range(1));
            ifc.iss_rs2_addr = 5'($urandom_range(7));
            ifc.iss_rs2_used = 1'($urandom_range(1));
            ifc.iss_rd_addr  = 5'($urandom_range(7));
            ifc.iss_rd_we    = ($urandom_range(3) != 0);
            ifc.wb_valid     = 1'($urandom_range(1));
            q.delete();
            for (int i = 1; i < 32; i++) if (m_busy[i]) q.push_back(i);
            if (q.size() > 0 && $urandom_range(7) != 0)
                pick = 5'(q[$urandom_range(q.size() - 1)]);
            else
                pick = 5'($urandom_range(15));
            ifc.wb_rd_addr = pick;
            run_cycle(1'b0, idle);
        end

        // Narrow stall counter must stop at all-ones.
        srst = 1'b0;
        sifc.flush = 1'b1;
        sifc.iss_valid = 1'b1;
        repeat (14) @(negedge clk);
        chk("sat_iss_ready", 64'(sifc.iss_ready), 64'(0));
        chk("sat_stall_14", 64'(sifc.stall_cnt), 64'(14));
        repeat (5) @(negedge clk);
        chk("sat_stall_hold", 64'(sifc.stall_cnt), 64'(15));
        srst = 1'b1;
        @(negedge clk);
        chk("sat_stall_rst", 64'(sifc.stall_cnt), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
